pcs_scrambler: RTL and testbench
================================

PCS_SCRAMBLER -- requirements
Module: pcs_scrambler

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: scr_in_data  in  66  encoded block; [1:0] sync header, [65:2] payload, payload bit i = scr_in_data[2+i].
REQ-004 SHALL have ports: scr_in_valid  in  1  scr_in_data holds a block.
REQ-005 SHALL have ports: scr_in_ready  out  1  block accepted when scr_in_valid & scr_in_ready.
REQ-006 SHALL have ports: scr_out_data  out  66  scrambled block, same bit layout as scr_in_data.
REQ-007 SHALL have ports: scr_out_valid  out  1  scr_out_data holds a block.
REQ-008 SHALL have ports: scr_out_ready  in  1  downstream accepts when scr_out_valid & scr_out_ready.
REQ-009 SHALL have ports: sync_hdr_err  out  1  registered with scr_out_data; high when that block's header is 2'b00 or 2'b11.
REQ-010 SHALL have, only when SCR_BYPASS_EN is defined: scr_bypass  in  1  pass payload unscrambled.

Function
REQ-011 SHALL scramble with polynomial x^58+x^39+1, self-synchronous, payload bit 0 first: out_i = in_i ^ out_(i-39) ^ out_(i-58).
REQ-012 SHALL hold a 58-bit state st[57:0], st[k] = scrambled bit k+1 positions back; per bit, tap st[38] and st[57], then shift the new scrambled bit into st[0].
REQ-013 SHALL compute all 64 payload bits of one block in a single cycle, unrolled, and advance the state by exactly 64 bits per accepted block.
REQ-014 SHALL pass the sync header [1:0] unmodified and exclude it from scrambling and state.
REQ-015 SHALL register the output: an accepted block appears on scr_out_data with scr_out_valid high on the next rising edge (latency 1).
REQ-016 SHALL drive scr_in_ready = ~scr_out_valid | scr_out_ready, combinationally.
REQ-017 SHALL hold scr_out_data, sync_hdr_err and state unchanged while scr_out_valid & ~scr_out_ready.
REQ-018 SHALL clear scr_out_valid on a cycle where the output is consumed and no new block is accepted.
REQ-019 SHALL, on simultaneous consume and accept, load the new block with no bubble, sustaining one block per cycle.
REQ-020 SHALL leave the state unchanged on cycles with no accepted block.
REQ-021 SHALL still scramble and forward blocks with an invalid header; sync_hdr_err only flags them.

Reset
REQ-022 SHALL on rst asynchronously set st to all ones (58'h3FF_FFFF_FFFF_FFFF), scr_out_valid 0, scr_out_data 0 and sync_hdr_err 0.
REQ-023 SHALL discard any held, unconsumed block when rst asserts mid-stream; the first block accepted after deassertion is scrambled from the all-ones seed.
REQ-024 SHALL drive scr_in_ready high while rst is asserted; blocks presented during reset SHALL NOT be captured.

Configuration
REQ-025 SHALL, with SCR_BYPASS_EN defined, forward the payload unscrambled and leave the state unchanged for each block accepted while scr_bypass=1; handshake, latency and sync_hdr_err are unaffected.
REQ-026 SHALL, without SCR_BYPASS_EN, omit scr_bypass and scramble every block.

Verification
REQ-027 SHALL cover: reset, then one block, header 2'b10, payload 64'h0 -> output header 2'b10, payload 64'h03FF_FF80_0000_0000, latency 1.
REQ-028 SHALL cover: 1000 random blocks with scr_out_ready always 1 through a reference descrambler (in_i = out_i ^ out_(i-39) ^ out_(i-58)) -> exact match from block 2 onward, one output per cycle.
REQ-029 SHALL cover: random scr_out_ready with 30% low duty -> no block lost, duplicated or reordered, output stable during stalls, and the same scrambled sequence as the no-stall run.
REQ-030 SHALL cover: headers 2'b00 and 2'b11 inserted among valid blocks -> sync_hdr_err=1 only on those blocks, with payloads still scrambled.
REQ-031 SHALL cover: rst pulse mid-stream with a stalled block held -> scr_out_valid=0 immediately, held block dropped, and a zero payload after reset gives 64'h03FF_FF80_0000_0000 again.
REQ-032 SHALL cover, with SCR_BYPASS_EN: bypass a block with payload 64'h0123_4567_89AB_CDEF -> identical output payload, and the next scrambled block equals the result with the bypassed block absent.

Source files
------------

// File: rtl/pcs_scrambler_if.sv
// Block handshake bundle for the 64b/66b PCS scrambler.
// Optional scr_bypass lane exists only with SCR_BYPASS_EN.
interface pcs_scrambler_if;
  logic [65:0] scr_in_data;
  logic        scr_in_valid;
  logic        scr_in_ready;
  logic [65:0] scr_out_data;
  logic        scr_out_valid;
  logic        scr_out_ready;
  logic        sync_hdr_err;
`ifdef SCR_BYPASS_EN
  logic        scr_bypass;

  modport slave (
    input  scr_in_data,
    input  scr_in_valid,
    output scr_in_ready,
    output scr_out_data,
    output scr_out_valid,
    input  scr_out_ready,
    output sync_hdr_err,
    input  scr_bypass
  );

  modport master (
    output scr_in_data,
    output scr_in_valid,
    input  scr_in_ready,
    input  scr_out_data,
    input  scr_out_valid,
    output scr_out_ready,
    input  sync_hdr_err,
    output scr_bypass
  );
`else
  modport slave (
    input  scr_in_data,
    input  scr_in_valid,
    output scr_in_ready,
    output scr_out_data,
    output scr_out_valid,
    input  scr_out_ready,
    output sync_hdr_err
  );

  modport master (
    output scr_in_data,
    output scr_in_valid,
    input  scr_in_ready,
    input  scr_out_data,
    input  scr_out_valid,
    output scr_out_ready,
    input  sync_hdr_err
  );
`endif
endinterface

// File: rtl/pcs_scrambler.sv
// 64b/66b self-synchronous scrambler, x^58+x^39+1, one block/cycle.
// Optional payload bypass enabled by defining SCR_BYPASS_EN.
module pcs_scrambler (
  input  logic              clk,
  input  logic              rst,
  pcs_scrambler_if.slave    bus
);

  logic [57:0] r_st;
  logic [65:0] r_out_data;
  logic        r_out_valid;
  logic        r_hdr_err;

  logic        w_accept;
  logic        w_bypass;
  logic [63:0] w_pay;
  logic [57:0] w_st_nxt;
  logic [63:0] w_pay_out;
  logic        w_hdr_bad;

  assign bus.scr_in_ready  = ~r_out_valid | bus.scr_out_ready;
  assign bus.scr_out_data  = r_out_data;
  assign bus.scr_out_valid = r_out_valid;
  assign bus.sync_hdr_err  = r_hdr_err;

  assign w_accept = bus.scr_in_valid & bus.scr_in_ready;

`ifdef SCR_BYPASS_EN
  assign w_bypass = bus.scr_bypass;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pay_out = w_bypass ? bus.scr_in_data[65:2] : w_pay;
  assign w_hdr_bad = ~(bus.scr_in_data[1] ^ bus.scr_in_data[0]);

  // Unrolled 64-step scramble; bit 0 goes first.
  always_comb begin : scramble
    logic [57:0] v_st;
    logic        v_b;
    v_st  = r_st;
    v_b   = 1'b0;
    w_pay = '0;
    for (int i = 0; i < 64; i++) begin
      v_b      = bus.scr_in_data[2+i] ^ v_st[38] ^ v_st[57];
      w_pay[i] = v_b;
      v_st     = {v_st[56:0], v_b};
    end
    w_st_nxt = v_st;
  end

  // Output register, handshake and scrambler state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st        <= '1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_hdr_err   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= {w_pay_out, bus.scr_in_data[1:0]};
      r_hdr_err   <= w_hdr_bad;
      if (!w_bypass)
        r_st <= w_st_nxt;
    end else if (bus.scr_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcs_scrambler.sv
// Self-checking bench for pcs_scrambler.
// Reference: bit-serial scrambler/descrambler over output-bit history.
module tb_pcs_scrambler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  localparam int NS = 1000;
  localparam int NST = 300;
  localparam logic [63:0] ZEXP = 64'h03FF_FF80_0000_0000;

  pcs_scrambler_if sif ();

  pcs_scrambler dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit hist[$];
  bit dh[$];

  logic [63:0] s_pay[NS];
  logic [1:0]  s_hdr[NS];
  logic [63:0] s_exp[NS];

  function automatic void model_reset();
    hist.delete();
    repeat (58) hist.push_back(1'b1);
    dh.delete();
  endfunction

  // out_i = in_i ^ out_(i-39) ^ out_(i-58)
  function automatic logic [63:0] model_scr(
    input logic [63:0] p);
    logic [63:0] r;
    bit b;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      b = p[i] ^ hist[hist.size()-39]
        ^ hist[hist.size()-58];
      r[i] = b;
      hist.push_back(b);
      void'(hist.pop_front());
    end
    return r;
  endfunction

  // in_i = out_i ^ out_(i-39) ^ out_(i-58)
  function automatic logic [63:0] model_desc(
    input logic [63:0] o);
    logic [63:0] r;
    bit b;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      b = o[i];
      if (dh.size() >= 58)
        b = b ^ dh[dh.size()-39] ^ dh[dh.size()-58];
      r[i] = b;
      dh.push_back(o[i]);
      if (dh.size() > 58) void'(dh.pop_front());
    end
    return r;
  endfunction

  function automatic logic [1:0] rnd_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    sif.scr_in_valid  = 1'b0;
    sif.scr_in_data   = '0;
    sif.scr_out_ready = 1'b1;
`ifdef SCR_BYPASS_EN
    sif.scr_bypass = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sif.scr_in_valid  = 1'b1;
    sif.scr_in_data   = {64'hDEAD_BEEF_0000_1111, 2'b01};
    sif.scr_out_ready = 1'b0;
`ifdef SCR_BYPASS_EN
    sif.scr_bypass = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sif.scr_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0",
               sif.scr_out_valid);
    end
    checks++;
    if (sif.scr_out_data !== 66'h0) begin
      errors++;
      $display("FAIL rst_data got %h want 0",
               sif.scr_out_data);
    end
    checks++;
    if (sif.sync_hdr_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_hdr_err got %b want 0",
               sif.sync_hdr_err);
    end
    checks++;
    if (sif.scr_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready got %b want 1",
               sif.scr_in_ready);
    end
    sif.scr_in_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [65:0] exp;
    exp = {model_scr(64'h0), 2'b10};
    sif.scr_out_ready = 1'b1;
    sif.scr_in_data   = {64'h0, 2'b10};
    sif.scr_in_valid  = 1'b1;
    checks++;
    if (exp !== {ZEXP, 2'b10}) begin
      errors++;
      $display("FAIL model_zero got %h want %h",
               exp, {ZEXP, 2'b10});
    end
    checks++;
    if (sif.scr_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pre_valid got %b want 0",
               sif.scr_out_valid);
    end
    @(posedge clk);
    #1;
    sif.scr_in_valid = 1'b0;
    checks++;
    if (sif.scr_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency got %b want 1",
               sif.scr_out_valid);
    end
    checks++;
    if (sif.scr_out_data !== {ZEXP, 2'b10}) begin
      errors++;
      $display("FAIL single_data got %h want %h",
               sif.scr_out_data, {ZEXP, 2'b10});
    end
    @(posedge clk);
    #1;
    checks++;
    if (sif.scr_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got %b want 0",
               sif.scr_out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_random_stream();
    logic [63:0] d;
    do_reset();
    sif.scr_out_ready = 1'b1;
    for (int n = 0; n < NS; n++) begin
      s_pay[n] = {$urandom, $urandom};
      s_hdr[n] = rnd_hdr();
      s_exp[n] = model_scr(s_pay[n]);
    end
    for (int n = 0; n <= NS; n++) begin
      if (n < NS) begin
        sif.scr_in_data  = {s_pay[n], s_hdr[n]};
        sif.scr_in_valid = 1'b1;
      end else begin
        sif.scr_in_valid = 1'b0;
      end
      @(negedge clk);
      if (n < NS) begin
        checks++;
        if (sif.scr_out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_valid blk %0d got %b want 1",
                   n, sif.scr_out_valid);
        end
        checks++;
        if (sif.scr_out_data !== {s_exp[n], s_hdr[n]}) begin
          errors++;
          $display("FAIL stream_data blk %0d got %h want %h",
                   n, sif.scr_out_data, {s_exp[n], s_hdr[n]});
        end
        checks++;
        if (sif.sync_hdr_err !== 1'b0) begin
          errors++;
          $display("FAIL stream_hdr_err blk %0d got %b want 0",
                   n, sif.sync_hdr_err);
        end
        d = model_desc(sif.scr_out_data[65:2]);
        if (n >= 1) begin
          checks++;
          if (d !== s_pay[n]) begin
            errors++;
            $display("FAIL descramble blk %0d got %h want %h",
                     n, d, s_pay[n]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    int sent;
    int got;
    int cyc;
    logic stalled;
    logic [65:0] prev;
    do_reset();
    sent = 0;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    prev = '0;
    while (got < NST && cyc < 5000) begin
      if (stalled) begin
        checks++;
        if (sif.scr_out_valid !== 1'b1 ||
            sif.scr_out_data !== prev) begin
          errors++;
          $display("FAIL stall_hold cyc %0d got %b/%h want 1/%h",
                   cyc, sif.scr_out_valid, sif.scr_out_data, prev);
        end
      end
      sif.scr_out_ready = ($urandom_range(0, 9) >= 3);
      sif.scr_in_valid = (sent < NST) &&
                         ($urandom_range(0, 3) != 0);
      if (sent < NST)
        sif.scr_in_data = {s_pay[sent], s_hdr[sent]};
      #1;
      checks++;
      if (sif.scr_in_ready !==
          (~sif.scr_out_valid | sif.scr_out_ready)) begin
        errors++;
        $display("FAIL in_ready cyc %0d got %b want %b",
                 cyc, sif.scr_in_ready,
                 ~sif.scr_out_valid | sif.scr_out_ready);
      end
      if (sif.scr_out_valid && sif.scr_out_ready) begin
        checks++;
        if (sif.scr_out_data !== {s_exp[got], s_hdr[got]}) begin
          errors++;
          $display("FAIL stall_data blk %0d got %h want %h",
                   got, sif.scr_out_data,
                   {s_exp[got], s_hdr[got]});
        end
        got++;
      end
      if (sif.scr_in_valid && sif.scr_in_ready)
        sent++;
      stalled = sif.scr_out_valid & ~sif.scr_out_ready;
      prev = sif.scr_out_data;
      @(negedge clk);
      cyc++;
    end
    sif.scr_in_valid = 1'b0;
    sif.scr_out_ready = 1'b1;
    checks++;
    if (got != NST) begin
      errors++;
      $display("FAIL stall_count got %0d want %0d", got, NST);
    end
    @(negedge clk);
    checks++;
    if (sif.scr_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_extra got %b want 0",
               sif.scr_out_valid);
    end
  endtask

  task automatic test_bad_header();
    logic [63:0] p;
    logic [63:0] e;
    logic [1:0]  h;
    logic        be;
    do_reset();
    sif.scr_out_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      p = {$urandom, $urandom};
      h = rnd_hdr();
      if (n == 5 || n == 30) h = 2'b00;
      if (n == 17 || n == 18) h = 2'b11;
      be = (h == 2'b00) || (h == 2'b11);
      e = model_scr(p);
      sif.scr_in_data = {p, h};
      sif.scr_in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (sif.sync_hdr_err !== be) begin
        errors++;
        $display("FAIL hdr_err blk %0d got %b want %b",
                 n, sif.sync_hdr_err, be);
      end
      checks++;
      if (sif.scr_out_data !== {e, h}) begin
        errors++;
        $display("FAIL hdr_data blk %0d got %h want %h",
                 n, sif.scr_out_data, {e, h});
      end
    end
    sif.scr_in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    sif.scr_out_ready = 1'b1;
    sif.scr_in_data = {64'hA5A5_0F0F_1234_5678, 2'b01};
    sif.scr_in_valid = 1'b1;
    @(negedge clk);
    sif.scr_out_ready = 1'b0;
    sif.scr_in_data = {64'h1111_2222_3333_4444, 2'b10};
    @(negedge clk);
    checks++;
    if (sif.scr_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_held got %b want 1",
               sif.scr_out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sif.scr_out_valid !== 1'b0 ||
        sif.scr_out_data !== 66'h0) begin
      errors++;
      $display("FAIL mid_rst got %b/%h want 0/0",
               sif.scr_out_valid, sif.scr_out_data);
    end
    checks++;
    if (sif.scr_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_ready got %b want 1",
               sif.scr_in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sif.scr_in_valid = 1'b0;
    sif.scr_out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (sif.scr_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_capture got %b want 0",
               sif.scr_out_valid);
    end
    sif.scr_in_data = {64'h0, 2'b01};
    sif.scr_in_valid = 1'b1;
    @(negedge clk);
    sif.scr_in_valid = 1'b0;
    checks++;
    if (sif.scr_out_valid !== 1'b1 ||
        sif.scr_out_data !== {ZEXP, 2'b01}) begin
      errors++;
      $display("FAIL mid_reseed got %b/%h want 1/%h",
               sif.scr_out_valid, sif.scr_out_data,
               {ZEXP, 2'b01});
    end
    @(negedge clk);
  endtask

`ifdef SCR_BYPASS_EN
  task automatic test_bypass();
    logic [63:0] a;
    logic [63:0] c;
    logic [63:0] ea;
    logic [63:0] ec;
    do_reset();
    a = {$urandom, $urandom};
    c = {$urandom, $urandom};
    ea = model_scr(a);
    ec = model_scr(c);
    sif.scr_out_ready = 1'b1;
    sif.scr_in_valid = 1'b1;
    sif.scr_in_data = {a, 2'b10};
    sif.scr_bypass = 1'b0;
    @(negedge clk);
    checks++;
    if (sif.scr_out_data !== {ea, 2'b10}) begin
      errors++;
      $display("FAIL byp_pre got %h want %h",
               sif.scr_out_data, {ea, 2'b10});
    end
    sif.scr_in_data = {64'h0123_4567_89AB_CDEF, 2'b11};
    sif.scr_bypass = 1'b1;
    @(negedge clk);
    checks++;
    if (sif.scr_out_data !==
        {64'h0123_4567_89AB_CDEF, 2'b11} ||
        sif.sync_hdr_err !== 1'b1) begin
      errors++;
      $display("FAIL byp_data got %h/%b want %h/1",
               sif.scr_out_data, sif.sync_hdr_err,
               {64'h0123_4567_89AB_CDEF, 2'b11});
    end
    sif.scr_in_data = {c, 2'b01};
    sif.scr_bypass = 1'b0;
    @(negedge clk);
    sif.scr_in_valid = 1'b0;
    checks++;
    if (sif.scr_out_data !== {ec, 2'b01}) begin
      errors++;
      $display("FAIL byp_post got %h want %h",
               sif.scr_out_data, {ec, 2'b01});
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    sif.scr_in_valid = 1'b0;
    sif.scr_in_data = '0;
    sif.scr_out_ready = 1'b1;
`ifdef SCR_BYPASS_EN
    sif.scr_bypass = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_single();
    test_random_stream();
    test_back_to_back_stall();
    test_bad_header();
    test_reset_midstream();
`ifdef SCR_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
